// File: rtl/flash_read_fsm.sv
// Single-word Avalon-MM flash read sequencer with a readdatavalid timeout.
// A held start causes one read only; RELEASE waits for start to drop.
module flash_read_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [22:0] address,
    output logic        finish,
    output logic [31:0] data,
    output logic        timeout_err,
    output logic        busy,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE,
        RELEASE
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [22:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    cnt_d   = '0;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // Returned data beats the timeout on the same edge.
                if (flash_mem_readdatavalid) begin
                    data_d  = flash_mem_readdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign finish               = (state_q == DONE);
    assign timeout_err          = finish & err_q;
    assign busy                 = (state_q != IDLE);
    assign flash_mem_read       = (state_q == REQ);
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign data                 = data_q;

endmodule

// File: tb/tb_flash_read_fsm.sv
// Directed bench for flash_read_fsm: cycle vector table followed by
// hand-written stall, timeout, held-start and reset-abort sequences.
module tb_flash_read_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [22:0] address;
    logic        finish;
    logic [31:0] data;
    logic        timeout_err;
    logic        busy;
    logic        rd;
    logic [22:0] maddr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] rdata;
    logic        rdv;

    int checks = 0;
    int errors = 0;
    int rd_cycles = 0;
    int acc_cnt = 0;
    int fin_cnt = 0;

    always #5 clk = ~clk;

    flash_read_fsm #(.TIMEOUT(255)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .address                 (address),
        .finish                  (finish),
        .data                    (data),
        .timeout_err             (timeout_err),
        .busy                    (busy),
        .flash_mem_read          (rd),
        .flash_mem_address       (maddr),
        .flash_mem_byteenable    (be),
        .flash_mem_waitrequest   (wr),
        .flash_mem_readdata      (rdata),
        .flash_mem_readdatavalid (rdv)
    );

    always @(posedge clk) begin
        if (rd) rd_cycles++;
        if (rd && !wr) acc_cnt++;
        if (finish) fin_cnt++;
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic [22:0] addr;
        logic        wr;
        logic        rdv;
        logic [31:0] rdata;
        logic        fin;
        logic        busy;
        logic        rd;
        logic [22:0] eaddr;
        logic [31:0] edata;
        logic        terr;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(
        input logic r, input logic s, input logic [22:0] a,
        input logic w, input logic v, input logic [31:0] d,
        input logic f, input logic b, input logic rr,
        input logic [22:0] ea, input logic [31:0] ed, input logic te);
        vec_t x;
        x.rst = r; x.start = s; x.addr = a; x.wr = w; x.rdv = v;
        x.rdata = d; x.fin = f; x.busy = b; x.rd = rr;
        x.eaddr = ea; x.edata = ed; x.terr = te;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic [22:0] a,
                         input logic w, input logic v, input logic [31:0] d);
        rst = r; start = s; address = a; wr = w; rdv = v; rdata = d;
    endtask

    task automatic clr_cnt();
        rd_cycles = 0; acc_cnt = 0; fin_cnt = 0;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        //            rst st addr    wr v  rdata         fin bsy rd eaddr   edata         te
        vt[0]  = mk(1, 0, 23'h0,  0, 0, 32'h0,        0, 0, 0, 23'h0,  32'h0,        0);
        vt[1]  = mk(0, 1, 23'h45, 0, 0, 32'h0,        0, 1, 1, 23'h45, 32'h0,        0);
        vt[2]  = mk(0, 1, 23'h45, 0, 0, 32'h0,        0, 1, 0, 23'h45, 32'h0,        0);
        vt[3]  = mk(0, 1, 23'h45, 0, 1, 32'hDEADBEEF, 1, 1, 0, 23'h45, 32'hDEADBEEF, 0);
        vt[4]  = mk(0, 1, 23'h45, 0, 0, 32'h0,        0, 1, 0, 23'h45, 32'hDEADBEEF, 0);
        vt[5]  = mk(0, 1, 23'h45, 0, 0, 32'h0,        0, 1, 0, 23'h45, 32'hDEADBEEF, 0);
        vt[6]  = mk(0, 0, 23'h45, 0, 0, 32'h0,        0, 0, 0, 23'h45, 32'hDEADBEEF, 0);
        vt[7]  = mk(0, 1, 23'h1,  0, 0, 32'h0,        0, 1, 1, 23'h1,  32'hDEADBEEF, 0);
        vt[8]  = mk(0, 1, 23'h7,  0, 0, 32'h0,        0, 1, 0, 23'h1,  32'hDEADBEEF, 0);
        vt[9]  = mk(0, 1, 23'h7,  0, 1, 32'h11111111, 1, 1, 0, 23'h1,  32'h11111111, 0);
        vt[10] = mk(0, 0, 23'h0,  0, 0, 32'h0,        0, 1, 0, 23'h1,  32'h11111111, 0);
        vt[11] = mk(0, 0, 23'h0,  0, 0, 32'h0,        0, 0, 0, 23'h1,  32'h11111111, 0);
        vt[12] = mk(0, 1, 23'h2,  0, 0, 32'h0,        0, 1, 1, 23'h2,  32'h11111111, 0);
        vt[13] = mk(0, 1, 23'h2,  0, 0, 32'h0,        0, 1, 0, 23'h2,  32'h11111111, 0);
        vt[14] = mk(0, 1, 23'h2,  0, 1, 32'h22222222, 1, 1, 0, 23'h2,  32'h22222222, 0);
        vt[15] = mk(0, 0, 23'h0,  0, 0, 32'h0,        0, 1, 0, 23'h2,  32'h22222222, 0);
        vt[16] = mk(0, 0, 23'h0,  0, 0, 32'h0,        0, 0, 0, 23'h2,  32'h22222222, 0);
        vt[17] = mk(0, 0, 23'h0,  0, 1, 32'h0BAD0BAD, 0, 0, 0, 23'h2,  32'h22222222, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].rst, vt[i].start, vt[i].addr,
                  vt[i].wr, vt[i].rdv, vt[i].rdata);
            tick();
            chk($sformatf("v%0d finish", i), 32'(finish), 32'(vt[i].fin));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("v%0d read", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("v%0d addr", i), 32'(maddr), 32'(vt[i].eaddr));
            chk($sformatf("v%0d data", i), data, vt[i].edata);
            chk($sformatf("v%0d terr", i), 32'(timeout_err), 32'(vt[i].terr));
            chk($sformatf("v%0d be", i), 32'(be), 32'hF);
        end

        // Stall: waitrequest high for three REQ cycles.
        clr_cnt();
        drive(0, 1, 23'h1234, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall read", 32'(rd), 32'h1);
            chk("stall addr", 32'(maddr), 32'h1234);
        end
        drive(0, 1, 23'h7777, 0, 0, '0);
        tick();
        chk("stall accept", 32'(rd), 32'h0);
        chk("stall addr hold", 32'(maddr), 32'h1234);
        drive(0, 1, 23'h7777, 0, 1, 32'hA5A5A5A5);
        tick();
        chk("stall finish", 32'(finish), 32'h1);
        drive(0, 0, '0, 0, 0, '0);
        tick();
        tick();
        chk("stall rd cycles", 32'(rd_cycles), 32'd4);
        chk("stall accepts", 32'(acc_cnt), 32'd1);
        chk("stall finishes", 32'(fin_cnt), 32'd1);
        chk("stall data", data, 32'hA5A5A5A5);
        chk("stall idle", 32'(busy), 32'h0);

        // Timeout: no readdatavalid, DONE reached 255 edges after entry.
        clr_cnt();
        drive(0, 1, 23'h55, 0, 0, '0);
        tick();
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("to pre finish", 32'(finish), 32'h0);
        chk("to pre busy", 32'(busy), 32'h1);
        chk("to pre count", 32'(fin_cnt), 32'd0);
        tick();
        chk("to finish", 32'(finish), 32'h1);
        chk("to err", 32'(timeout_err), 32'h1);
        chk("to data", data, 32'h0);
        drive(0, 0, '0, 0, 0, '0);
        tick();
        chk("to err cleared", 32'(timeout_err), 32'h0);
        tick();
        chk("to idle", 32'(busy), 32'h0);

        // readdatavalid on the timeout edge wins.
        drive(0, 1, 23'h66, 0, 0, '0);
        tick();
        tick();
        for (int i = 0; i < 254; i++) tick();
        drive(0, 1, 23'h66, 0, 1, 32'hCAFEF00D);
        tick();
        chk("race finish", 32'(finish), 32'h1);
        chk("race err", 32'(timeout_err), 32'h0);
        chk("race data", data, 32'hCAFEF00D);
        drive(0, 0, '0, 0, 0, '0);
        tick();
        tick();

        // Held start across completion gives one read only.
        clr_cnt();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 23'h99, 0, (i == 2), 32'h0F0F0F0F);
            tick();
        end
        chk("held busy", 32'(busy), 32'h1);
        drive(0, 0, '0, 0, 0, '0);
        tick();
        tick();
        chk("held accepts", 32'(acc_cnt), 32'd1);
        chk("held finishes", 32'(fin_cnt), 32'd1);
        chk("held data", data, 32'h0F0F0F0F);

        // Reset mid-read, then a stale readdatavalid.
        drive(1, 1, 23'h3, 0, 0, '0);
        tick();
        chk("rst dom start", 32'(busy), 32'h0);
        chk("rst data", data, 32'h0);
        clr_cnt();
        drive(0, 1, 23'h9, 0, 0, '0);
        tick();
        tick();
        chk("abort in wait", 32'(busy), 32'h1);
        drive(1, 1, 23'h9, 0, 0, '0);
        tick();
        chk("abort idle", 32'(busy), 32'h0);
        chk("abort addr", 32'(maddr), 32'h0);
        drive(0, 0, '0, 0, 1, 32'h12345678);
        tick();
        drive(0, 0, '0, 0, 0, '0);
        tick();
        chk("abort data", data, 32'h0);
        chk("abort finish", 32'(fin_cnt), 32'd0);
        chk("abort busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_read_fsm.md
FLASH_READ_FSM -- requirements
Module: flash_read_fsm

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waited in WAIT_DATA for readdatavalid, range 1..255.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  read request from address handler; level, sampled only in IDLE.
REQ-005 address  in  23  flash word address; captured on the accepting edge.
REQ-006 finish  out  1  one-cycle pulse, read complete; data valid from same cycle.
REQ-007 data  out  32  last word read; held until next completion.
REQ-008 timeout_err  out  1  high with finish when the read timed out; otherwise 0.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 flash_mem_read  out  1  Avalon-MM read strobe.
REQ-011 flash_mem_address  out  23  Avalon-MM word address.
REQ-012 flash_mem_byteenable  out  4  Avalon-MM byte enables.
REQ-013 flash_mem_waitrequest  in  1  slave stall; read not accepted while high.
REQ-014 flash_mem_readdata  in  32  returned word.
REQ-015 flash_mem_readdatavalid  in  1  readdata valid this cycle.

Function
REQ-016 States: IDLE, REQ, WAIT_DATA, DONE, RELEASE; all outputs registered or decoded from state only.
REQ-017 IDLE: start=1 -> REQ next edge, address latched into flash_mem_address; start=0 -> stay.
REQ-018 REQ: flash_mem_read=1, address stable; waitrequest=1 -> stay; waitrequest=0 -> WAIT_DATA (read accepted that edge).
REQ-019 flash_mem_read SHALL be 1 only in REQ, never in any other state.
REQ-020 flash_mem_byteenable SHALL be 4'b1111 constantly.
REQ-021 WAIT_DATA: readdatavalid=1 -> data <= readdata, timeout_err <= 0, go DONE.
REQ-022 WAIT_DATA: 8-bit counter cleared on entry, +1 per cycle without readdatavalid; at count==TIMEOUT-1 with no readdatavalid -> data <= 32'h0, timeout_err <= 1, go DONE.
REQ-023 readdatavalid in the same cycle as the timeout condition SHALL win (data taken, no error).
REQ-024 readdatavalid in IDLE, REQ, DONE, RELEASE SHALL be ignored; data unchanged.
REQ-025 DONE: finish=1 for exactly one cycle, then unconditionally -> RELEASE.
REQ-026 RELEASE: start=1 -> stay; start=0 -> IDLE; prevents re-trigger by a held start.
REQ-027 timeout_err SHALL be valid only while finish=1 and forced 0 elsewhere.
REQ-028 start or address changes outside IDLE SHALL be ignored; in-flight read uses latched address.
REQ-029 Minimum latency, start sampled at edge k, waitrequest=0, readdatavalid 1 cycle after accept: read at k+1, data in WAIT_DATA at k+2, finish at k+3.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 rst=1 at an edge SHALL force IDLE from any state, including mid-read, next edge.
REQ-032 Reset values: finish=0, timeout_err=0, busy=0, flash_mem_read=0, flash_mem_address=0, data=32'h0, counter=0.
REQ-033 A readdatavalid returning after a reset-aborted read SHALL be ignored (IDLE).
REQ-034 rst dominates start when both high.

Verification
REQ-035 Basic read: address=23'h000045, start held high, waitrequest=0, readdatavalid+readdata=32'hDEADBEEF 1 cycle after accept -> one read strobe at 23'h000045, finish 1 cycle with data=32'hDEADBEEF, timeout_err=0, IDLE only after start drops.
REQ-036 Stall: waitrequest high 3 cycles -> flash_mem_read held 4 cycles, address stable; finish exactly once after readdatavalid.
REQ-037 Timeout: TIMEOUT=255, readdatavalid never asserted -> finish with timeout_err=1, data=32'h0, 255 cycles after WAIT_DATA entry.
REQ-038 Held start: start high 20 cycles across completion -> exactly one read strobe and one finish pulse.
REQ-039 Reset mid-read: rst=1 in WAIT_DATA, then readdatavalid with 32'h12345678 -> IDLE, no finish, data stays 32'h0.
REQ-040 Back-to-back: start 23'h000001, complete, drop start, start 23'h000002 -> two reads at correct addresses, data updates per completion.
